fft_result_server: RTL

FFT_RESULT_SERVER -- requirements
Module: fft_result_server

---
 rtl/fft_result_server_if.sv | 34 +++
 rtl/fft_result_server.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fft_result_server_if.sv
// fft_result_server_if: groups the FFT streaming sink, the Nios command word and
// the result exports of fft_result_server into one bundle.
//   sink_valid/sop/eop, sink_real/imag : FFT core Avalon-ST output (into the block)
//   sink_ready                         : block accepts bins
//   pc_cmd                             : [9:0] read bin index, [31] release bit
//   fft_real/fft_img                   : addressed bin contents
//   fft_start                          : frame held and readable
//   fft_cnt                            : bins in held frame minus 1
// master: FFT core / Nios side. slave: fft_result_server.
interface fft_result_server_if #(
  parameter int unsigned DATA_W = 24
) ();
  logic                     sink_valid;
  logic                     sink_sop;
  logic                     sink_eop;
  logic signed [DATA_W-1:0] sink_real;
  logic signed [DATA_W-1:0] sink_imag;
  logic                     sink_ready;
  logic [31:0]              pc_cmd;
  logic signed [DATA_W-1:0] fft_real;
  logic signed [DATA_W-1:0] fft_img;
  logic                     fft_start;
  logic [9:0]               fft_cnt;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, pc_cmd,
    input  sink_ready, fft_real, fft_img, fft_start, fft_cnt
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, pc_cmd,
    output sink_ready, fft_real, fft_img, fft_start, fft_cnt
  );
endinterface

// File: rtl/fft_result_server.sv
// fft_result_server: captures one FFT frame from an Avalon-ST source into a
// single-port RAM, then holds it for the Nios to read bin by bin until the Nios
// toggles the release bit.
//   clk_clk       : system clock (rising edge)
//   reset_reset_n : asynchronous active-low reset, release synchronised
//   bus           : fft_result_server_if.slave (sink stream, pc_cmd, result exports)
module fft_result_server #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned DATA_W    = 24
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  fft_result_server_if.slave bus
);

  localparam int unsigned    IdxW    = 10;
  localparam int unsigned    WordW   = 2 * DATA_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StReady} state_e;

  // Reset: asserts immediately, releases two clocks later.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync_q <= 2'b00;
    else                rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  state_e              state_q, state_d;
  logic [IdxW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0]     cnt_q, cnt_d;
  logic                rel_q, rel_d;
  logic [DATA_W-1:0]   real_q, real_d;
  logic [DATA_W-1:0]   imag_q, imag_d;
  logic [WordW-1:0]    rd_q;
  logic [WordW-1:0]    mem [FRAME_LEN];

  logic                wr_en;
  logic [IdxW-1:0]     wr_addr;
  logic [IdxW-1:0]     ram_addr;
  logic                rel_edge;
  logic                unused_pc;

  assign unused_pc = ^bus.pc_cmd[30:IdxW];
  assign rel_edge  = bus.pc_cmd[31] & ~rel_q;
  assign rel_d     = bus.pc_cmd[31];

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_addr  = wr_cnt_q;
    unique case (state_q)
      StIdle: begin
        // Only a start-of-frame beat opens a capture; anything else is dropped.
        if (bus.sink_valid && bus.sink_sop) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          if (bus.sink_eop) begin
            state_d  = StReady;
            cnt_d    = '0;
            wr_cnt_d = '0;
          end else begin
            state_d  = StCapture;
            wr_cnt_d = IdxW'(1);
          end
        end
      end
      StCapture: begin
        if (bus.sink_valid) begin
          wr_en   = 1'b1;
          // A fresh sop restarts the frame at bin 0.
          wr_addr = bus.sink_sop ? '0 : wr_cnt_q;
          if (bus.sink_eop || (wr_addr == LastIdx)) begin
            state_d  = StReady;
            cnt_d    = wr_addr;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_addr + IdxW'(1);
          end
        end
      end
      StReady: begin
        if (rel_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write port owns the address while capturing; the Nios index otherwise.
  assign ram_addr = wr_en ? wr_addr : bus.pc_cmd[IdxW-1:0];

  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[ram_addr] <= {bus.sink_real, bus.sink_imag};
    rd_q <= mem[ram_addr];
  end

  // Second pipeline stage; frozen outside READY so the exports hold.
  always_comb begin
    real_d = real_q;
    imag_d = imag_q;
    if (state_q == StReady) begin
      real_d = rd_q[WordW-1:DATA_W];
      imag_d = rd_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_cnt_q <= '0;
      cnt_q    <= '0;
      rel_q    <= 1'b0;
      real_q   <= '0;
      imag_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      real_q   <= real_d;
      imag_q   <= imag_d;
    end
  end

  assign bus.sink_ready = (state_q != StReady);
  assign bus.fft_start  = (state_q == StReady);
  assign bus.fft_cnt    = cnt_q;
  assign bus.fft_real   = real_q;
  assign bus.fft_img    = imag_q;

endmodule
